regfile: RTL and testbench
==========================

# regfile

Integer register file for the rv64IM pipeline, sitting at the receiving end of the writeback stage's register-write interface (`rf_wen`/`rd`/`rf_wdata`) and serving operand reads to decode. It holds x1–x31 and keeps a per-register pending-write scoreboard, set at issue and retired at writeback, so decode can detect RAW hazards. Same-cycle writeback data is bypassed to the read ports. It also exports a0 for the exit/trap check.

## Interface
- `XLEN`, 64: register width.
- `CNT_W`, 2: width of each per-register pending-write counter. Up to 2^CNT_W−1 writes may be outstanding per register.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `rf_wen_i` input 1: writeback write enable.
- `rd_i` input 5: writeback destination register.
- `rf_wdata_i` input XLEN: writeback data.
- `rs1_i`, `rs2_i` input 5 each: decode read addresses.
- `rs1_rdata_o`, `rs2_rdata_o` output XLEN each: read data (combinational).
- `rs1_busy_o`, `rs2_busy_o` output 1 each: the register still has an uncommitted write pending.
- `issue_valid_i` input 1: an instruction writing `issue_rd_i` issues this cycle.
- `issue_rd_i` input 5: destination of the issuing instruction.
- `issue_ready_o` output 1: issue is accepted. The issue takes effect only when `issue_valid_i && issue_ready_o`.
- `flush_i` input 1: pipeline flush; discards all pending-write tracking.
- `pending_o` output 1: OR of all pending counters being nonzero.
- `a0_o` output XLEN: current committed value of x10 (debug/exit value).

## Operation
**Storage**
- 31 registers × XLEN. x0 reads 0 and is never stored.
- Write occurs at the clock edge when `rf_wen_i && rd_i != 0`.
- Writes to x0 are ignored without error.

**Reads**
- `rsN_rdata_o` = 0 if `rsN_i == 0`.
- Otherwise, if `rf_wen_i && rd_i == rsN_i`, it equals `rf_wdata_i` (bypass).
- Otherwise it is the array value.

**Scoreboard**
- Each of x1–x31 has a CNT_W-bit counter `cnt[r]`.
- Increment when an issue is accepted with `issue_rd_i == r`.
- Decrement when `rf_wen_i && rd_i == r`.
- If both happen to the same r in one cycle, the net change is 0.
- A decrement when the count is already 0 is a protocol error: the count stays 0 and a simulation-only `$display` warning is printed.

**Busy**
- `rsN_busy_o` = (`cnt[rsN] > 1`) OR (`cnt[rsN] == 1` AND NOT (`rf_wen_i && rd_i == rsN`)).
- Equivalently: busy unless the last pending write is being bypassed this cycle.
- x0 is never busy.

**Issue handshake**
- `issue_ready_o` = 0 only when `issue_rd_i != 0` and `cnt[issue_rd_i]` is all-ones and no writeback to `issue_rd_i` occurs this cycle.
- Issue to x0 is always ready and has no effect.

**Flush**
- When `flush_i` = 1, all counters become 0 at the next edge, overriding any issue or writeback count update in the same cycle.
- The writeback data write in that cycle is still performed, because it is a committed instruction.

**Reset**
- All registers become 0 and all counters become 0 at the next edge.
- After reset:
  - `rsN_rdata_o` = 0.
  - `rsN_busy_o` = 0.
  - `issue_ready_o` = 1.
  - `pending_o` = 0.
  - `a0_o` = 0.
- Reset mid-operation discards in-flight tracking with no warnings.

## Timing
- Read latency 0 (combinational).
- A write becomes visible through the array the cycle after the edge, and through the bypass in the same cycle.
- Scoreboard effects:
  - Issue accepted in cycle t → busy visible from cycle t+1.
  - Writeback in cycle t → busy deasserts combinationally in cycle t if it was the last pending write.
- `a0_o` reflects the array only (no bypass); it updates the cycle after a write to x10.
- `pending_o` is registered-state derived; it deasserts the cycle after the last counter reaches 0.

## Test plan
- **Reset:** assert `rst` for 2 cycles with random inputs → all read data 0, busy 0, `issue_ready_o` 1, `a0_o` 0.
- **Write, bypass, x0:**
  - Write x5 = 0xDEAD_BEEF_0000_0001 with `rs1_i` = 5 in the same cycle → `rs1_rdata_o` = that value in the same cycle, and from the array in the next cycle.
  - Write x0 = 0x1234 → reads of x0 return 0.
- **Basic RAW:**
  - Issue rd = 7 at t0 → `rs2_busy_o` (`rs2_i` = 7) = 1 from t1.
  - Writeback x7 = 0x42 at t3 → busy 0 and rdata 0x42 in t3.
- **WAW and saturation (CNT_W = 2):**
  - Issue rd = 3 three times → `cnt` = 3; a 4th issue sees `issue_ready_o` = 0.
  - Writeback x3 once → busy stays 1; ready = 1 with that writeback present.
  - After 3 writebacks → busy 0.
- **Simultaneous issue and writeback to the same register:** `cnt[9]` = 1, issue rd = 9 plus writeback x9 in the same cycle → `cnt` stays 1 and x9 remains busy next cycle.
- **Flush and a0:**
  - Issue x10 and x11, then `flush_i` with a concurrent writeback x10 = 0x0 → all busy 0 next cycle, `pending_o` 0, x10 written.
  - Writeback x10 = 0x1 → `a0_o` = 0x1 one cycle later.

Source files
------------

// File: rtl/regfile_if.sv
// Register file port bundle: writeback write, decode reads, issue scoreboard
// handshake, flush, and debug/status outputs.
// slave = register file side, master = pipeline (or bench) side.
interface regfile_if #(
  parameter int XLEN = 64
);
  // Writeback write port
  logic            rf_wen_i;
  logic [4:0]      rd_i;
  logic [XLEN-1:0] rf_wdata_i;
  // Decode read ports
  logic [4:0]      rs1_i;
  logic [4:0]      rs2_i;
  logic [XLEN-1:0] rs1_rdata_o;
  logic [XLEN-1:0] rs2_rdata_o;
  logic            rs1_busy_o;
  logic            rs2_busy_o;
  // Issue handshake into the pending-write scoreboard
  logic            issue_valid_i;
  logic [4:0]      issue_rd_i;
  logic            issue_ready_o;
  // Control / status
  logic            flush_i;
  logic            pending_o;
  logic [XLEN-1:0] a0_o;

  modport slave (
    input  rf_wen_i, rd_i, rf_wdata_i, rs1_i, rs2_i,
    input  issue_valid_i, issue_rd_i, flush_i,
    output rs1_rdata_o, rs2_rdata_o, rs1_busy_o, rs2_busy_o,
    output issue_ready_o, pending_o, a0_o
  );

  modport master (
    output rf_wen_i, rd_i, rf_wdata_i, rs1_i, rs2_i,
    output issue_valid_i, issue_rd_i, flush_i,
    input  rs1_rdata_o, rs2_rdata_o, rs1_busy_o, rs2_busy_o,
    input  issue_ready_o, pending_o, a0_o
  );
endinterface

// File: rtl/regfile.sv
// Integer register file x1..x31 with writeback bypass and per-register
// pending-write counters for RAW hazard detection.
// Latency: reads/busy combinational; writes and counters update on the clock
// edge. Backpressure: issue_ready_o drops only when the destination counter is
// saturated and no writeback frees a slot in the same cycle.
// Ports: clk, rst (sync, active-high), rf (regfile_if.slave bundle).
module regfile #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 2
) (
  input logic     clk,
  input logic     rst,
  regfile_if.slave rf
);

  logic [XLEN-1:0]  regs_q [1:31];
  logic [XLEN-1:0]  regs_d [1:31];
  logic [CNT_W-1:0] cnt_q  [1:31];
  logic [CNT_W-1:0] cnt_d  [1:31];

  logic [31:1]      wb_hit;
  logic [31:1]      iss_hit;
  logic             issue_ready;
  logic             issue_fire;
  logic             wb_underflow;
  logic             any_pending;

  // Issue is refused only if the target counter is full and no writeback to the
  // same register frees a slot this cycle (that pair nets to zero change).
  always_comb begin
    issue_ready = 1'b1;
    if (rf.issue_rd_i != 5'd0) begin
      if ((&cnt_q[rf.issue_rd_i]) &&
          !(rf.rf_wen_i && (rf.rd_i == rf.issue_rd_i))) begin
        issue_ready = 1'b0;
      end
    end
  end

  // Issue to x0 is accepted but tracks nothing.
  assign issue_fire = rf.issue_valid_i && issue_ready && (rf.issue_rd_i != 5'd0);

  always_comb begin
    wb_hit  = '0;
    iss_hit = '0;
    for (int r = 1; r < 32; r++) begin
      wb_hit[r]  = rf.rf_wen_i && (rf.rd_i == 5'(r));
      iss_hit[r] = issue_fire && (rf.issue_rd_i == 5'(r));
    end
  end

  // Read ports: x0 hard zero, then same-cycle writeback bypass, then array.
  always_comb begin
    rf.rs1_rdata_o = '0;
    rf.rs1_busy_o  = 1'b0;
    if (rf.rs1_i != 5'd0) begin
      if (rf.rf_wen_i && (rf.rd_i == rf.rs1_i)) rf.rs1_rdata_o = rf.rf_wdata_i;
      else                                      rf.rs1_rdata_o = regs_q[rf.rs1_i];
      // Busy unless the last outstanding write is being bypassed right now.
      rf.rs1_busy_o = (cnt_q[rf.rs1_i] > CNT_W'(1)) ||
                      ((cnt_q[rf.rs1_i] == CNT_W'(1)) &&
                       !(rf.rf_wen_i && (rf.rd_i == rf.rs1_i)));
    end
  end

  always_comb begin
    rf.rs2_rdata_o = '0;
    rf.rs2_busy_o  = 1'b0;
    if (rf.rs2_i != 5'd0) begin
      if (rf.rf_wen_i && (rf.rd_i == rf.rs2_i)) rf.rs2_rdata_o = rf.rf_wdata_i;
      else                                      rf.rs2_rdata_o = regs_q[rf.rs2_i];
      rf.rs2_busy_o = (cnt_q[rf.rs2_i] > CNT_W'(1)) ||
                      ((cnt_q[rf.rs2_i] == CNT_W'(1)) &&
                       !(rf.rf_wen_i && (rf.rd_i == rf.rs2_i)));
    end
  end

  // Next-state for the array; writebacks commit even during a flush.
  always_comb begin
    regs_d = regs_q;
    if (rf.rf_wen_i && (rf.rd_i != 5'd0)) regs_d[rf.rd_i] = rf.rf_wdata_i;
  end

  // Next-state for the scoreboard. Flush wins over any count movement.
  always_comb begin
    cnt_d        = cnt_q;
    wb_underflow = 1'b0;
    for (int r = 1; r < 32; r++) begin
      if (wb_hit[r] && !iss_hit[r] && (cnt_q[r] == '0)) wb_underflow = 1'b1;
      if (rf.flush_i) begin
        cnt_d[r] = '0;
      end else if (iss_hit[r] && !wb_hit[r]) begin
        cnt_d[r] = cnt_q[r] + CNT_W'(1);
      end else if (wb_hit[r] && !iss_hit[r] && (cnt_q[r] != '0)) begin
        cnt_d[r] = cnt_q[r] - CNT_W'(1);
      end
    end
  end

  always_comb begin
    any_pending = 1'b0;
    for (int r = 1; r < 32; r++) begin
      if (cnt_q[r] != '0) any_pending = 1'b1;
    end
  end

  assign rf.issue_ready_o = issue_ready;
  assign rf.pending_o     = any_pending;
  assign rf.a0_o          = regs_q[10];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 1; r < 32; r++) begin
        regs_q[r] <= '0;
        cnt_q[r]  <= '0;
      end
    end else begin
      regs_q <= regs_d;
      cnt_q  <= cnt_d;
    end
  end

`ifndef SYNTHESIS
  // Writeback with nothing outstanding is a pipeline protocol slip; the counter
  // simply holds at zero, so only report it.
  always_ff @(posedge clk) begin
    if (!rst && wb_underflow) begin
      $display("regfile: warning: writeback to x%0d with no pending write", rf.rd_i);
    end
  end
`endif

endmodule

// File: tb/tb_regfile.sv
// Directed self-checking bench for regfile: reset, bypass, x0, RAW, WAW
// saturation, simultaneous issue/writeback, flush and a0.
module tb_regfile;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  regfile_if #(.XLEN(64)) rif ();

  regfile #(.XLEN(64), .CNT_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .rf  (rif.slave)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rif.rf_wen_i      = 1'b0;
    rif.rd_i          = 5'd0;
    rif.rf_wdata_i    = '0;
    rif.rs1_i         = 5'd0;
    rif.rs2_i         = 5'd0;
    rif.issue_valid_i = 1'b0;
    rif.issue_rd_i    = 5'd0;
    rif.flush_i       = 1'b0;
  endtask

  task automatic wb(input logic [4:0] r, input logic [63:0] d);
    rif.rf_wen_i   = 1'b1;
    rif.rd_i       = r;
    rif.rf_wdata_i = d;
  endtask

  task automatic issue(input logic [4:0] r);
    rif.issue_valid_i = 1'b1;
    rif.issue_rd_i    = r;
  endtask

  initial begin
    // ---------------- reset with random inputs ----------------
    idle();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      rif.rf_wen_i      = 1'b1;
      rif.rd_i          = 5'($urandom_range(1, 31));
      rif.rf_wdata_i    = {$urandom(), $urandom()};
      rif.issue_valid_i = 1'b1;
      rif.issue_rd_i    = 5'($urandom_range(1, 31));
      rif.flush_i       = 1'($urandom_range(0, 1));
      tick();
    end
    rst = 1'b0;
    idle();
    rif.rs1_i      = 5'd5;
    rif.rs2_i      = 5'd10;
    rif.issue_rd_i = 5'd3;
    #1;
    check("rst_rs1_rdata", rif.rs1_rdata_o, 64'h0);
    check("rst_rs2_rdata", rif.rs2_rdata_o, 64'h0);
    check("rst_rs1_busy", {63'd0, rif.rs1_busy_o}, 64'h0);
    check("rst_rs2_busy", {63'd0, rif.rs2_busy_o}, 64'h0);
    check("rst_ready", {63'd0, rif.issue_ready_o}, 64'h1);
    check("rst_pending", {63'd0, rif.pending_o}, 64'h0);
    check("rst_a0", rif.a0_o, 64'h0);

    // ---------------- write x5 with bypass ----------------
    tick();
    idle();
    wb(5'd5, 64'hDEAD_BEEF_0000_0001);
    rif.rs1_i = 5'd5;
    #1;
    check("byp_x5", rif.rs1_rdata_o, 64'hDEAD_BEEF_0000_0001);
    check("byp_x5_busy", {63'd0, rif.rs1_busy_o}, 64'h0);
    tick();
    idle();
    rif.rs1_i = 5'd5;
    #1;
    check("arr_x5", rif.rs1_rdata_o, 64'hDEAD_BEEF_0000_0001);

    // ---------------- write to x0 ignored ----------------
    tick();
    idle();
    wb(5'd0, 64'h1234);
    #1;
    check("x0_byp_rs1", rif.rs1_rdata_o, 64'h0);
    check("x0_byp_rs2", rif.rs2_rdata_o, 64'h0);
    tick();
    idle();
    #1;
    check("x0_arr", rif.rs1_rdata_o, 64'h0);

    // ---------------- basic RAW on x7 ----------------
    tick();
    idle();
    issue(5'd7);
    rif.rs2_i = 5'd7;
    #1;
    check("raw_t0_ready", {63'd0, rif.issue_ready_o}, 64'h1);
    check("raw_t0_busy", {63'd0, rif.rs2_busy_o}, 64'h0);
    tick();
    idle();
    rif.rs2_i = 5'd7;
    #1;
    check("raw_t1_busy", {63'd0, rif.rs2_busy_o}, 64'h1);
    check("raw_t1_pending", {63'd0, rif.pending_o}, 64'h1);
    tick();
    #1;
    check("raw_t2_busy", {63'd0, rif.rs2_busy_o}, 64'h1);
    tick();
    wb(5'd7, 64'h42);
    #1;
    check("raw_t3_busy", {63'd0, rif.rs2_busy_o}, 64'h0);
    check("raw_t3_rdata", rif.rs2_rdata_o, 64'h42);
    tick();
    idle();
    rif.rs2_i = 5'd7;
    #1;
    check("raw_t4_busy", {63'd0, rif.rs2_busy_o}, 64'h0);
    check("raw_t4_rdata", rif.rs2_rdata_o, 64'h42);
    check("raw_t4_pending", {63'd0, rif.pending_o}, 64'h0);

    // ---------------- WAW saturation on x3 ----------------
    for (int i = 0; i < 3; i++) begin
      tick();
      idle();
      issue(5'd3);
      #1;
      check("sat_ready_accept", {63'd0, rif.issue_ready_o}, 64'h1);
    end
    tick();
    idle();
    issue(5'd3);
    rif.rs1_i = 5'd3;
    #1;
    check("sat_ready_full", {63'd0, rif.issue_ready_o}, 64'h0);
    check("sat_busy_full", {63'd0, rif.rs1_busy_o}, 64'h1);
    tick();
    idle();
    wb(5'd3, 64'h33);
    rif.issue_rd_i = 5'd3;
    rif.rs1_i      = 5'd3;
    #1;
    check("sat_ready_wb", {63'd0, rif.issue_ready_o}, 64'h1);
    check("sat_busy_wb1", {63'd0, rif.rs1_busy_o}, 64'h1);
    tick();
    #1;
    check("sat_busy_wb2", {63'd0, rif.rs1_busy_o}, 64'h1);
    tick();
    #1;
    check("sat_busy_wb3", {63'd0, rif.rs1_busy_o}, 64'h0);
    tick();
    idle();
    rif.rs1_i = 5'd3;
    #1;
    check("sat_busy_after", {63'd0, rif.rs1_busy_o}, 64'h0);
    check("sat_pending_after", {63'd0, rif.pending_o}, 64'h0);

    // ---------------- simultaneous issue + writeback on x9 ----------------
    tick();
    idle();
    issue(5'd9);
    tick();
    idle();
    issue(5'd9);
    wb(5'd9, 64'h99);
    rif.rs1_i = 5'd9;
    #1;
    check("sim_busy_same", {63'd0, rif.rs1_busy_o}, 64'h0);
    tick();
    idle();
    rif.rs1_i = 5'd9;
    #1;
    check("sim_busy_next", {63'd0, rif.rs1_busy_o}, 64'h1);
    check("sim_rdata_next", rif.rs1_rdata_o, 64'h99);

    // ---------------- flush with concurrent writeback, a0 ----------------
    tick();
    idle();
    wb(5'd10, 64'h55);
    tick();
    idle();
    #1;
    check("a0_pre", rif.a0_o, 64'h55);
    issue(5'd10);
    tick();
    idle();
    issue(5'd11);
    tick();
    idle();
    rif.rs1_i = 5'd10;
    rif.rs2_i = 5'd11;
    #1;
    check("fl_busy10_pre", {63'd0, rif.rs1_busy_o}, 64'h1);
    check("fl_busy11_pre", {63'd0, rif.rs2_busy_o}, 64'h1);
    check("fl_pending_pre", {63'd0, rif.pending_o}, 64'h1);
    rif.flush_i = 1'b1;
    wb(5'd10, 64'h0);
    tick();
    idle();
    rif.rs1_i = 5'd10;
    rif.rs2_i = 5'd11;
    #1;
    check("fl_busy10", {63'd0, rif.rs1_busy_o}, 64'h0);
    check("fl_busy11", {63'd0, rif.rs2_busy_o}, 64'h0);
    check("fl_pending", {63'd0, rif.pending_o}, 64'h0);
    check("fl_x10_written", rif.rs1_rdata_o, 64'h0);
    check("fl_a0", rif.a0_o, 64'h0);
    wb(5'd10, 64'h1);
    #1;
    check("a0_no_bypass", rif.a0_o, 64'h0);
    tick();
    idle();
    #1;
    check("a0_update", rif.a0_o, 64'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
